union_find_pc: RTL and testbench
================================

Name: union_find_pc

Overview:
- Parametrised union-find engine for connected-component labelling in the 720P image-processing pipeline.
- Holds a parent table for N labels with four operations: find, union, same-set query and table clear.
- Union always makes the smaller root the new root, so canonical labels are always minimum labels. Find applies path halving.
- A start/busy/done handshake lets the labelling FSM issue one operation at a time.

Parameters:
N, 64, number of labels (any value >= 2, not required to be a power of two)
ADDR_WIDTH, $clog2(N), label index width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  operation request; sampled only when busy=0
op  in  2  00 FIND, 01 UNION, 10 SAME, 11 CLEAR
node1  in  ADDR_WIDTH  first operand
node2  in  ADDR_WIDTH  second operand (UNION/SAME only)
busy  out  1  engine not idle; start ignored
done  out  1  one-cycle completion pulse
result  out  ADDR_WIDTH  root produced by the last operation
same  out  1  operands were in the same set (UNION/SAME)
err  out  1  an operand was >= N

Behaviour:
- Storage: parent[0..N-1] in a register array, with combinational reads of parent[x] and parent[parent[x]].
- Reset (rst_n low, asynchronous):
  - done=0, result=0, same=0, err=0, busy=1.
  - State forced to INIT; any in-flight operation is abandoned.
- States: INIT, IDLE, WALK_A, WALK_B, LINK, DONE.
- INIT:
  - Writes parent[i]=i for i=0..N-1, one entry per cycle; busy=1 throughout.
  - After N cycles, moves to IDLE with busy=0.
  - CLEAR enters INIT the same way, and done pulses when INIT finishes.
- IDLE:
  - On start=1, latches op, node1 and node2, then sets busy=1.
  - If any used operand is >= N: go to DONE with err=1, result=0, same=0, table unchanged.
  - Otherwise go to WALK_A with x=node1 (CLEAR goes to INIT).
  - start while busy=1 is dropped with no queueing.
- WALK_A / WALK_B, one hop per cycle:
  - If parent[x]==x, the root is found. WALK_A stores ra and WALK_B stores rb.
  - Otherwise write parent[x] <= parent[parent[x]] and set x <= parent[parent[x]] (path halving). The root is preserved.
  - After WALK_A: FIND goes to DONE; UNION/SAME go to WALK_B with x=node2.
  - After WALK_B: SAME goes to DONE; UNION goes to LINK.
- LINK:
  - If ra==rb: same=1, no write.
  - Else write parent[max(ra,rb)] <= min(ra,rb), same=0.
  - result=min(ra,rb).
- Results per op:
  - FIND: result=ra.
  - SAME: result=ra, same=(ra==rb).
- DONE:
  - done=1 for exactly one cycle, then IDLE with busy=0.
  - result, same and err hold until the next accepted start, which clears err/same.
- Latency, counted in cycles from the accept edge:
  - A walk at depth d takes 1+ceil(d/2) cycles.
  - FIND: done = walkA+1.
  - SAME: done = walkA+walkB+1.
  - UNION: done = walkA+walkB+2.
  - Singleton FIND: done visible 2 cycles after the accept edge.
- Invariants:
  - A parent index is always <= the child index, so walks terminate within N cycles and no loop guard is needed.
  - A node with node1==node2 in UNION gives same=1 and no write.
  - Simultaneous start and done: start is ignored because busy is still 1 in DONE.

Test Plan:
1. N=8, release rst_n → busy=1 for exactly 8 cycles, then 0. FIND(5) → done pulse 2 cycles after accept, result=5, err=0. A start pulsed during INIT is ignored (no done).
2. UNION(1,2), UNION(3,4) → result 1, then 3. FIND(2)=1, FIND(4)=3. SAME(1,4) → same=0, result=1.
3. UNION(5,6), UNION(6,1) → result=1. FIND(6)=1, FIND(5)=1. SAME(2,5) → same=1. UNION(2,5) → same=1, result=1, table unchanged.
4. After CLEAR, UNION(k,k+1) for k=6..0 builds chain 7→6→…→0:
   - First FIND(7) → result 0 with 5 walk cycles; parent[7]=5, parent[5]=3, parent[3]=1.
   - Second FIND(7) → result 0 with 3 walk cycles.
5. CLEAR after step 3 → busy=1 for 8 cycles, done pulse, then FIND(6)=6 and SAME(1,2) same=0. Separately, drop rst_n mid-walk of FIND(7) → done never pulses, busy=1, INIT runs, then FIND(7)=7.
6. N=6, ADDR_WIDTH=3:
   - FIND(7) → err=1, result=0, done 2 cycles after accept.
   - UNION(2,6) → err=1, table unchanged, so FIND(2)=2.
   - A following valid FIND(3) clears err, result=3.

Source files
------------

// File: rtl/union_find_pc.sv
// Union-find engine with min-root linking and path-halving find, used for
// connected-component labelling. One operation at a time via start/busy/done.
module union_find_pc #(
  parameter int unsigned N          = 64,
  parameter int unsigned ADDR_WIDTH = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [ADDR_WIDTH-1:0] node1,
  input  logic [ADDR_WIDTH-1:0] node2,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] result,
  output logic                  same,
  output logic                  err
);

  typedef enum logic [2:0] {StInit, StIdle, StWalkA, StWalkB, StLink, StDone} state_e;

  localparam logic [1:0] OpFind  = 2'b00;
  localparam logic [1:0] OpUnion = 2'b01;
  localparam logic [1:0] OpSame  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] n2_q, n2_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d;
  logic [ADDR_WIDTH-1:0] ra_q, ra_d;
  logic [ADDR_WIDTH-1:0] rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  clr_q, clr_d;
  logic [ADDR_WIDTH-1:0] result_q, result_d;
  logic                  same_q, same_d;
  logic                  err_q, err_d;

  logic [ADDR_WIDTH-1:0] parent_q [N];
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr, wdata;

  logic [ADDR_WIDTH-1:0] p, pp;
  logic                  n1_bad, n2_bad, bad;

  assign p  = parent_q[x_q];
  assign pp = parent_q[p];

  assign n1_bad = 32'(node1) >= N;
  assign n2_bad = 32'(node2) >= N;
  // FIND ignores node2, CLEAR ignores both operands.
  assign bad    = (op != OpClear) &&
                  (n1_bad || (((op == OpUnion) || (op == OpSame)) && n2_bad));

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n2_d     = n2_q;
    x_d      = x_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    cnt_d    = cnt_q;
    clr_d    = clr_q;
    result_d = result_q;
    same_d   = same_q;
    err_d    = err_q;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;

    unique case (state_q)
      StInit: begin
        we    = 1'b1;
        waddr = cnt_q;
        wdata = cnt_q;
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (32'(cnt_q) == N - 1) begin
          cnt_d   = '0;
          clr_d   = 1'b0;
          state_d = clr_q ? StDone : StIdle;
        end
      end
      StIdle: begin
        if (start) begin
          op_d   = op;
          n2_d   = node2;
          x_d    = node1;
          err_d  = 1'b0;
          same_d = 1'b0;
          if (op == OpClear) begin
            clr_d   = 1'b1;
            cnt_d   = '0;
            state_d = StInit;
          end else if (bad) begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = StDone;
          end else begin
            state_d = StWalkA;
          end
        end
      end
      StWalkA: begin
        if (p == x_q) begin
          ra_d = x_q;
          if (op_q == OpFind) begin
            result_d = x_q;
            state_d  = StDone;
          end else begin
            x_d     = n2_q;
            state_d = StWalkB;
          end
        end else begin
          we    = 1'b1;
          waddr = x_q;
          wdata = pp;
          x_d   = pp;
        end
      end
      StWalkB: begin
        if (p == x_q) begin
          rb_d = x_q;
          if (op_q == OpSame) begin
            result_d = ra_q;
            same_d   = (ra_q == x_q);
            state_d  = StDone;
          end else begin
            state_d = StLink;
          end
        end else begin
          we    = 1'b1;
          waddr = x_q;
          wdata = pp;
          x_d   = pp;
        end
      end
      StLink: begin
        same_d   = (ra_q == rb_q);
        result_d = (ra_q < rb_q) ? ra_q : rb_q;
        if (ra_q != rb_q) begin
          we    = 1'b1;
          waddr = (ra_q < rb_q) ? rb_q : ra_q;
          wdata = (ra_q < rb_q) ? ra_q : rb_q;
        end
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StInit;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      op_q     <= OpFind;
      n2_q     <= '0;
      x_q      <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      cnt_q    <= '0;
      clr_q    <= 1'b0;
      result_q <= '0;
      same_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      n2_q     <= n2_d;
      x_q      <= x_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      cnt_q    <= cnt_d;
      clr_q    <= clr_d;
      result_q <= result_d;
      same_q   <= same_d;
      err_q    <= err_d;
    end
  end

  // Table contents are rebuilt by INIT after every reset, so no reset here.
  always_ff @(posedge clk) begin
    if (we) begin
      parent_q[waddr] <= wdata;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign same   = same_q;
  assign err    = err_q;

endmodule

// File: tb/tb_union_find_pc.sv
// Bench for union_find_pc: an N=8 and an N=6 instance sharing operand inputs,
// driven from a vector table and checked through an expected-result queue.
module tb_union_find_pc;

  localparam int unsigned AW = 3;
  localparam logic [1:0] F = 2'b00, U = 2'b01, S = 2'b10, C = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start8 = 1'b0, start6 = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [AW-1:0] node1 = '0, node2 = '0;
  logic          busy8, done8, same8, err8;
  logic          busy6, done6, same6, err6;
  logic [AW-1:0] res8, res6;

  union_find_pc #(.N(8), .ADDR_WIDTH(AW)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .op(op), .node1(node1), .node2(node2),
    .busy(busy8), .done(done8), .result(res8), .same(same8), .err(err8)
  );

  union_find_pc #(.N(6), .ADDR_WIDTH(AW)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .op(op), .node1(node1), .node2(node2),
    .busy(busy6), .done(done6), .result(res6), .same(same6), .err(err6)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          sel;
    logic [1:0]  op;
    logic [AW-1:0] n1, n2, r;
    bit          chk_r, s, e;
    int          lat;
  } vec_t;

  typedef struct {
    bit          sel;
    logic [AW-1:0] r;
    bit          chk_r, s, e;
    int          lat, acc;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   c8, c6;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit sel, logic [1:0] o, int a, int b, int r, bit cr, bit s,
                              bit e, int lat);
    vec_t v;
    v.sel = sel; v.op = o; v.n1 = 3'(a); v.n2 = 3'(b); v.r = 3'(r);
    v.chk_r = cr; v.s = s; v.e = e; v.lat = lat;
    return v;
  endfunction

  // Latency = posedges from the accept edge up to the edge that leaves DONE.
  exp_t m;
  always @(negedge clk) begin
    if (done8 || done6) begin
      if (sb.size() == 0) begin
        check("spurious_done", int'(done8) + int'(done6), 0);
      end else begin
        m = sb.pop_front();
        check("done_dut", int'(done6), int'(m.sel));
        if (m.chk_r) check("result", int'(m.sel ? res6 : res8), int'(m.r));
        check("same", int'(m.sel ? same6 : same8), int'(m.s));
        check("err", int'(m.sel ? err6 : err8), int'(m.e));
        if (m.lat >= 0) check("latency", cyc - m.acc + 1, m.lat);
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t x;
    int   t;
    t = 0;
    while ((v.sel ? busy6 : busy8) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("idle_wait", int'(v.sel ? busy6 : busy8), 0);
    op = v.op; node1 = v.n1; node2 = v.n2;
    if (v.sel) start6 = 1'b1;
    else       start8 = 1'b1;
    x.sel = v.sel; x.r = v.r; x.chk_r = v.chk_r; x.s = v.s; x.e = v.e; x.lat = v.lat;
    x.acc = cyc + 1;
    sb.push_back(x);
    @(negedge clk);
    start8 = 1'b0;
    start6 = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_wait", sb.size(), 0);
    sb.delete();
  endtask

  task automatic count_init();
    c8 = 0;
    c6 = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy8) c8++;
      if (busy6) c6++;
      @(negedge clk);
    end
  endtask

  initial begin
    // sel, op, node1, node2, result, check result, same, err, latency (-1: unchecked)
    tv.push_back(mk(0, F, 5, 0, 5, 1, 0, 0, 2));
    tv.push_back(mk(0, U, 1, 2, 1, 1, 0, 0, 4));
    tv.push_back(mk(0, U, 3, 4, 3, 1, 0, 0, 4));
    tv.push_back(mk(0, F, 2, 0, 1, 1, 0, 0, 3));
    tv.push_back(mk(0, F, 4, 0, 3, 1, 0, 0, 3));
    tv.push_back(mk(0, S, 1, 4, 1, 1, 0, 0, 4));
    tv.push_back(mk(0, U, 5, 6, 5, 1, 0, 0, 4));
    tv.push_back(mk(0, U, 6, 1, 1, 1, 0, 0, 5));
    tv.push_back(mk(0, F, 6, 0, 1, 1, 0, 0, 3));
    tv.push_back(mk(0, F, 5, 0, 1, 1, 0, 0, 3));
    tv.push_back(mk(0, S, 2, 5, 1, 1, 1, 0, 5));
    tv.push_back(mk(0, U, 2, 5, 1, 1, 1, 0, 6));
    tv.push_back(mk(0, F, 2, 0, 1, 1, 0, 0, 3));
    tv.push_back(mk(0, C, 0, 0, 0, 0, 0, 0, 9));
    tv.push_back(mk(0, F, 6, 0, 6, 1, 0, 0, 2));
    tv.push_back(mk(0, S, 1, 2, 1, 1, 0, 0, 3));
    tv.push_back(mk(0, C, 0, 0, 0, 0, 0, 0, 9));
    for (int k = 6; k >= 0; k--) tv.push_back(mk(0, U, k, k + 1, k, 1, 0, 0, 4));
    tv.push_back(mk(0, F, 7, 0, 0, 1, 0, 0, 6));
    tv.push_back(mk(0, F, 7, 0, 0, 1, 0, 0, 4));
    tv.push_back(mk(0, F, 5, 0, 0, 1, 0, 0, 3));
    tv.push_back(mk(1, F, 7, 0, 0, 1, 0, 1, -1));
    tv.push_back(mk(1, F, 3, 0, 3, 1, 0, 0, 2));
    tv.push_back(mk(1, U, 2, 6, 0, 1, 0, 1, -1));
    tv.push_back(mk(1, F, 2, 0, 2, 1, 0, 0, 2));
    tv.push_back(mk(1, S, 1, 7, 0, 1, 0, 1, -1));
    tv.push_back(mk(1, S, 1, 2, 1, 1, 0, 0, 3));
    tv.push_back(mk(1, F, 4, 7, 4, 1, 0, 0, 2));
    tv.push_back(mk(1, F, 5, 0, 5, 1, 0, 0, 2));

    repeat (3) @(negedge clk);
    check("rst_busy8", int'(busy8), 1);
    check("rst_busy6", int'(busy6), 1);
    check("rst_done8", int'(done8), 0);
    check("rst_result8", int'(res8), 0);
    check("rst_same8", int'(same8), 0);
    check("rst_err8", int'(err8), 0);

    // A start pulsed during INIT must be dropped; the monitor flags any done.
    rst_n = 1'b1;
    c8 = 0;
    c6 = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy8) c8++;
      if (busy6) c6++;
      start8 = (i == 2);
      @(negedge clk);
    end
    start8 = 1'b0;
    check("init_busy8", c8, 8);
    check("init_busy6", c6, 6);

    foreach (tv[i]) issue(tv[i]);

    // Reset in the middle of a FIND walk abandons it and reruns INIT.
    op = F; node1 = 3'd7; node2 = 3'd0;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("walk_busy", int'(busy8), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy8), 1);
    check("midrst_done", int'(done8), 0);
    check("midrst_result", int'(res8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_init();
    check("reinit_busy8", c8, 8);
    check("reinit_busy6", c6, 6);
    issue(mk(0, F, 7, 0, 7, 1, 0, 0, 2));
    issue(mk(1, F, 5, 0, 5, 1, 0, 0, 2));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
